// File: rtl/adc_frame_pkg.sv
// -----------------------------------------------------------------------------
// adc_frame_pkg
// Shared definitions for the ADC frame packer: frame geometry, default sync
// bytes, transmit FSM state type, and the snapshot record that holds one
// eight-channel conversion plus the sequence number it was tagged with.
// -----------------------------------------------------------------------------
package adc_frame_pkg;

  localparam int unsigned NUM_CH      = 8;
  localparam int unsigned DATA_BYTES  = 2 * NUM_CH;
  localparam int unsigned FRAME_BYTES = DATA_BYTES + 4;  // sync x2, seq, data, csum

  localparam logic [7:0] SYNC0_DEF = 8'hA5;
  localparam logic [7:0] SYNC1_DEF = 8'h5A;

  // Explicit encodings keep the state register value identical to the
  // legacy build for anyone probing it on a logic analyser.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC_A = 3'd1,
    ST_SYNC_B = 3'd2,
    ST_SEQ    = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5
  } state_e;

  // ch[0] is channel 1.
  typedef struct packed {
    logic [NUM_CH-1:0][15:0] ch;
    logic [7:0]              seq;
  } snapshot_t;

  // Data byte idx (0..15) of a snapshot: even idx = high byte, odd = low byte.
  function automatic logic [7:0] snap_byte(snapshot_t s, logic [3:0] idx);
    logic [15:0] w;
    w = s.ch[idx[3:1]];
    return idx[0] ? w[7:0] : w[15:8];
  endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// -----------------------------------------------------------------------------
// adc_frame_packer_if
// Byte-wide valid/ready stream carrying framed packets to the host link.
//   tx_data  : current frame byte
//   tx_valid : tx_data valid
//   tx_ready : sink accepts the byte when tx_valid & tx_ready
// master = packer side, slave = link side.
// -----------------------------------------------------------------------------
interface adc_frame_packer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/adc_snapshot_buf.sv
// -----------------------------------------------------------------------------
// adc_snapshot_buf
// Two-slot snapshot holding registers. The pending slot receives new
// snapshots; a transfer copies pending into the active slot, which the
// transmitter reads while the pending slot is free for the next sample.
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_en_i      : load wr_data_i into the pending slot (caller guarantees
//                  the slot is empty or being transferred this cycle)
//   wr_data_i    : snapshot to store
//   xfer_i       : move pending -> active and free the pending slot
//   pend_full_o  : pending slot occupied
//   act_data_o   : active slot contents
// A write and a transfer in the same cycle are both honoured: the old
// pending goes to active and the new snapshot takes its place.
// -----------------------------------------------------------------------------
module adc_snapshot_buf
  import adc_frame_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_en_i,
  input  snapshot_t wr_data_i,
  input  logic      xfer_i,
  output logic      pend_full_o,
  output snapshot_t act_data_o
);

  snapshot_t pend_q, pend_d;
  snapshot_t act_q,  act_d;
  logic      pend_full_q, pend_full_d;

  always_comb begin
    pend_d      = pend_q;
    act_d       = act_q;
    pend_full_d = pend_full_q;
    if (xfer_i) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (wr_en_i) begin
      pend_d      = wr_data_i;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      act_q       <= '0;
      pend_full_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      act_q       <= act_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign pend_full_o = pend_full_q;
  assign act_data_o  = act_q;

endmodule

// File: rtl/adc_frame_packer.sv
// -----------------------------------------------------------------------------
// adc_frame_packer
// Snapshots the eight AD7606 channel words on each completed conversion and
// streams them as a 20-byte frame:
//   SYNC0, SYNC1, SEQ, ch1[15:8], ch1[7:0], ... ch8[7:0], CSUM
// CSUM = (SEQ + sum of the 16 data bytes) mod 256.
// A pending + active snapshot pair absorbs link back-pressure; a sample that
// finds the pending slot still occupied is dropped and counted.
//   sys_clk, rst_n          : clock, asynchronous active-low reset
//   pack_enable             : accept new sample events when 1
//   adc_read_done           : capture-complete flag (rising edge used)
//   adc_ch1..8_data         : channel words, stable while adc_read_done high
//   tx                      : byte stream (master)
//   busy                    : frame in flight or pending slot full
//   seq_num                 : sequence number of the next sample event
//   drop_cnt                : saturating dropped-frame count
// -----------------------------------------------------------------------------
module adc_frame_packer
  import adc_frame_pkg::*;
#(
  parameter logic [7:0] SYNC0 = SYNC0_DEF,
  parameter logic [7:0] SYNC1 = SYNC1_DEF
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic                      pack_enable,
  input  logic                      adc_read_done,
  input  logic [15:0]               adc_ch1_data,
  input  logic [15:0]               adc_ch2_data,
  input  logic [15:0]               adc_ch3_data,
  input  logic [15:0]               adc_ch4_data,
  input  logic [15:0]               adc_ch5_data,
  input  logic [15:0]               adc_ch6_data,
  input  logic [15:0]               adc_ch7_data,
  input  logic [15:0]               adc_ch8_data,
  adc_frame_packer_if.master        tx,
  output logic                      busy,
  output logic [7:0]                seq_num,
  output logic [15:0]               drop_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(DATA_BYTES - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  seq_q;
  logic [15:0] drop_q;
  logic        rd_prev_q;

  logic        sample_evt;
  logic        hs;
  logic        xfer;
  logic        wr_en;
  logic        drop;
  logic        pend_full;
  logic        tx_valid_w;
  logic [7:0]  tx_data_w;
  logic [7:0]  data_byte;
  snapshot_t   snap_in;
  snapshot_t   act;

  // ---------------------------------------------------------------------------
  // Sample event detection and snapshot capture
  // ---------------------------------------------------------------------------
  assign sample_evt = adc_read_done & ~rd_prev_q & pack_enable;

  always_comb begin
    snap_in.ch[0] = adc_ch1_data;
    snap_in.ch[1] = adc_ch2_data;
    snap_in.ch[2] = adc_ch3_data;
    snap_in.ch[3] = adc_ch4_data;
    snap_in.ch[4] = adc_ch5_data;
    snap_in.ch[5] = adc_ch6_data;
    snap_in.ch[6] = adc_ch7_data;
    snap_in.ch[7] = adc_ch8_data;
    snap_in.seq   = seq_q;
  end

  assign hs = tx_valid_w & tx.tx_ready;

  // Pending moves to active whenever the transmitter is idle, or on the
  // checksum handshake so the next frame follows with no idle cycle.
  assign xfer  = pend_full & ((state_q == ST_IDLE) | ((state_q == ST_CSUM) & hs));
  // A transfer in the same cycle frees the slot, so a coincident sample
  // is still accepted.
  assign wr_en = sample_evt & (~pend_full | xfer);
  assign drop  = sample_evt & ~wr_en;

  adc_snapshot_buf u_buf (
    .clk         (sys_clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en),
    .wr_data_i   (snap_in),
    .xfer_i      (xfer),
    .pend_full_o (pend_full),
    .act_data_o  (act)
  );

  // ---------------------------------------------------------------------------
  // Transmit FSM and checksum accumulator
  // ---------------------------------------------------------------------------
  assign data_byte = snap_byte(act, idx_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_full) state_d = ST_SYNC_A;
      end
      ST_SYNC_A: begin
        if (hs) state_d = ST_SYNC_B;
      end
      ST_SYNC_B: begin
        if (hs) state_d = ST_SEQ;
      end
      ST_SEQ: begin
        if (hs) begin
          state_d = ST_DATA;
          idx_d   = '0;
          csum_d  = act.seq;
        end
      end
      ST_DATA: begin
        if (hs) begin
          csum_d = csum_q + data_byte;
          if (idx_q == LAST_IDX) state_d = ST_CSUM;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      ST_CSUM: begin
        if (hs) state_d = pend_full ? ST_SYNC_A : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      csum_q    <= '0;
      seq_q     <= '0;
      drop_q    <= '0;
      rd_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      rd_prev_q <= adc_read_done;
      if (sample_evt)             seq_q  <= seq_q + 8'd1;
      if (drop && (drop_q != '1)) drop_q <= drop_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output byte mux: a pure function of registered state, so the byte only
  // changes on a handshake or frame start and drops to idle on async reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_valid_w = (state_q != ST_IDLE);
    case (state_q)
      ST_SYNC_A: tx_data_w = SYNC0;
      ST_SYNC_B: tx_data_w = SYNC1;
      ST_SEQ:    tx_data_w = act.seq;
      ST_DATA:   tx_data_w = data_byte;
      ST_CSUM:   tx_data_w = csum_q;
      default:   tx_data_w = '0;
    endcase
  end

  assign tx.tx_valid = tx_valid_w;
  assign tx.tx_data  = tx_data_w;
  assign busy        = (state_q != ST_IDLE) | pend_full;
  assign seq_num     = seq_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
module tb_adc_frame_packer;
  import adc_frame_pkg::*;

  typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        pack_enable;
  logic        adc_read_done;
  logic [15:0] ch [NUM_CH];
  logic        busy;
  logic [7:0]  seq_num;
  logic [15:0] drop_cnt;

  adc_frame_packer_if tx_if();

  adc_frame_packer #(.SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .pack_enable   (pack_enable),
    .adc_read_done (adc_read_done),
    .adc_ch1_data  (ch[0]),
    .adc_ch2_data  (ch[1]),
    .adc_ch3_data  (ch[2]),
    .adc_ch4_data  (ch[3]),
    .adc_ch5_data  (ch[4]),
    .adc_ch6_data  (ch[5]),
    .adc_ch7_data  (ch[6]),
    .adc_ch8_data  (ch[7]),
    .tx            (tx_if),
    .busy          (busy),
    .seq_num       (seq_num),
    .drop_cnt      (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: a frame queue of depth one waiting behind the frame on
  // the wire, tracked as "bytes remaining" of the frame being sent.
  frame_t      m_cur, m_pend;
  int          m_left;
  bit          m_pend_full;
  logic [7:0]  m_seq;
  logic [15:0] m_drop;
  logic        m_prev;
  logic [7:0]  rx_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic frame_t build_frame(input logic [7:0] s);
    frame_t f;
    int unsigned sum;
    f[0] = 8'hA5;
    f[1] = 8'h5A;
    f[2] = s;
    sum  = s;
    for (int k = 0; k < NUM_CH; k++) begin
      f[3 + 2*k] = ch[k][15:8];
      f[4 + 2*k] = ch[k][7:0];
      sum += ch[k][15:8] + ch[k][7:0];
    end
    f[19] = 8'(sum % 256);
    return f;
  endfunction

  task automatic model_reset();
    m_left = 0; m_pend_full = 0; m_seq = '0; m_drop = '0; m_prev = 1'b0;
    m_cur = '0; m_pend = '0;
  endtask

  // Advance the model over the coming clock edge, using the inputs now applied.
  task automatic model_step();
    bit hs, ev, frees;
    hs    = (m_left > 0) && (tx_if.tx_ready === 1'b1);
    ev    = adc_read_done && !m_prev && pack_enable;
    frees = m_pend_full && (m_left == 0 || (hs && m_left == 1));
    if (hs) begin
      rx_q.push_back(tx_if.tx_data);
      m_left--;
    end
    if (frees) begin
      m_cur = m_pend; m_left = FRAME_BYTES; m_pend_full = 0;
    end
    if (ev) begin
      if (!m_pend_full) begin
        m_pend = build_frame(m_seq); m_pend_full = 1;
      end else if (m_drop != 16'hFFFF) begin
        m_drop++;
      end
      m_seq++;
    end
    m_prev = adc_read_done;
  endtask

  task automatic compare();
    check("tx_valid", 32'(tx_if.tx_valid), 32'(m_left > 0));
    if (m_left > 0) check("tx_data", 32'(tx_if.tx_data), 32'(m_cur[FRAME_BYTES - m_left]));
    check("busy", 32'(busy), 32'((m_left > 0) || m_pend_full));
    check("seq_num", 32'(seq_num), 32'(m_seq));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    adc_read_done = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic rand_ch();
    for (int k = 0; k < NUM_CH; k++) ch[k] = 16'($urandom);
  endtask

  initial begin
    frame_t      exp_f;
    logic [7:0]  seq_save;
    logic [15:0] drop_save;
    int          guard;

    rst_n = 1'b0; pack_enable = 1'b1; adc_read_done = 1'b0;
    tx_if.tx_ready = 1'b1;
    for (int k = 0; k < NUM_CH; k++) ch[k] = '0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("rst_tx_data",  32'(tx_if.tx_data),  32'd0);
    check("rst_busy",     32'(busy),           32'd0);
    check("rst_seq",      32'(seq_num),        32'd0);
    check("rst_drop",     32'(drop_cnt),       32'd0);
    rst_n = 1'b1;

    // Single frame, channels 1..8, seq 0.
    for (int k = 0; k < NUM_CH; k++) ch[k] = 16'(k + 1);
    rx_q.delete();
    adc_read_done = 1'b1; tick();
    check("lat_no_valid_yet", 32'(tx_if.tx_valid), 32'd0);
    adc_read_done = 1'b0; tick();
    check("lat_first_byte", 32'(tx_if.tx_data), 32'hA5);
    repeat (22) tick();
    check("t1_len", 32'(rx_q.size()), 32'd20);
    if (rx_q.size() == 20) begin
      check("t1_b0",  32'(rx_q[0]),  32'hA5);
      check("t1_b1",  32'(rx_q[1]),  32'h5A);
      check("t1_seq", 32'(rx_q[2]),  32'h00);
      check("t1_b3",  32'(rx_q[3]),  32'h00);
      check("t1_b4",  32'(rx_q[4]),  32'h01);
      check("t1_b18", 32'(rx_q[18]), 32'h08);
      check("t1_csum",32'(rx_q[19]), 32'h24);
    end
    check("t1_seq_num", 32'(seq_num), 32'd1);

    // Back-pressure: ready toggling every cycle.
    rand_ch();
    exp_f = build_frame(8'd1);
    rx_q.delete();
    adc_read_done = 1'b1; tick();
    adc_read_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tx_if.tx_ready = i[0];
      tick();
    end
    tx_if.tx_ready = 1'b1;
    check("bp_len", 32'(rx_q.size()), 32'd20);
    if (rx_q.size() == 20)
      for (int i = 0; i < FRAME_BYTES; i++) check("bp_byte", 32'(rx_q[i]), 32'(exp_f[i]));

    // Overflow: three events with ready low.
    do_reset();
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_ch();
      adc_read_done = 1'b1; tick();
      adc_read_done = 1'b0; tick();
    end
    check("ovf_drop", 32'(drop_cnt), 32'd1);
    check("ovf_seq",  32'(seq_num),  32'd3);
    rx_q.delete();
    tx_if.tx_ready = 1'b1;
    repeat (45) tick();
    check("ovf_len", 32'(rx_q.size()), 32'd40);
    if (rx_q.size() == 40) begin
      check("ovf_seq_a", 32'(rx_q[2]),  32'h00);
      check("ovf_seq_b", 32'(rx_q[22]), 32'h01);
    end

    // Event coincident with CSUM handshake while pending is full.
    drop_save = m_drop;
    rx_q.delete();
    rand_ch(); adc_read_done = 1'b1; tick();
    adc_read_done = 1'b0; tick();
    rand_ch(); adc_read_done = 1'b1; tick();
    adc_read_done = 1'b0;
    guard = 0;
    while (m_left != 1 && guard < 40) begin tick(); guard++; end
    rand_ch(); adc_read_done = 1'b1; tick();
    adc_read_done = 1'b0;
    check("sim_drop", 32'(drop_cnt), 32'(drop_save));
    check("sim_busy", 32'(busy), 32'd1);
    repeat (50) tick();
    check("sim_len", 32'(rx_q.size()), 32'd60);

    // pack_enable low: events ignored; then a long high level is one event.
    seq_save = m_seq; drop_save = m_drop;
    pack_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adc_read_done = 1'b1; tick();
      adc_read_done = 1'b0; tick();
    end
    check("en0_seq",   32'(seq_num),        32'(seq_save));
    check("en0_drop",  32'(drop_cnt),       32'(drop_save));
    check("en0_valid", 32'(tx_if.tx_valid), 32'd0);
    pack_enable = 1'b1;
    adc_read_done = 1'b1;
    repeat (100) tick();
    adc_read_done = 1'b0;
    repeat (5) tick();
    check("hold_seq", 32'(seq_num), 32'(8'(seq_save + 8'd1)));

    // Reset during DATA byte 7.
    rand_ch(); adc_read_done = 1'b1; tick();
    adc_read_done = 1'b0;
    repeat (11) tick();
    check("mid_valid_before", 32'(tx_if.tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(tx_if.tx_valid), 32'd0);
    check("mid_data",  32'(tx_if.tx_data),  32'd0);
    check("mid_busy",  32'(busy),           32'd0);
    check("mid_seq",   32'(seq_num),        32'd0);
    check("mid_drop",  32'(drop_cnt),       32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    rx_q.delete();
    rand_ch(); adc_read_done = 1'b1; tick();
    adc_read_done = 1'b0;
    repeat (23) tick();
    check("post_rst_len", 32'(rx_q.size()), 32'd20);
    if (rx_q.size() == 20) check("post_rst_seq", 32'(rx_q[2]), 32'h00);

    // Randomised traffic with varying link back-pressure.
    for (int seg = 0; seg < 6; seg++) begin
      int unsigned rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int i = 0; i < 500; i++) begin
        tx_if.tx_ready = ($urandom_range(1, 100) <= rdy_pct);
        pack_enable    = ($urandom_range(0, 7) != 0);
        if (!adc_read_done) begin
          adc_read_done = ($urandom_range(0, 9) == 0);
          if (adc_read_done) rand_ch();
        end else begin
          adc_read_done = ($urandom_range(0, 2) != 0);
        end
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
